// File: rtl/approx_error_monitor.sv
// approx_error_monitor: windowed error statistics for an approximate adder with a valid/ready report
module approx_error_monitor #(
    parameter int WIDTH  = 8,
    parameter int WINDOW = 256,
    parameter int CNT_W  = $clog2(WINDOW + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         a,
    input  logic [WIDTH-1:0]         b,
    input  logic                     cin,
    input  logic [WIDTH-1:0]         approx_sum,
    input  logic                     approx_cout,
    input  logic                     flush,
    output logic                     rpt_valid,
    input  logic                     rpt_ready,
    output logic [CNT_W-1:0]         rpt_samples,
    output logic [CNT_W-1:0]         rpt_err_count,
    output logic [WIDTH+CNT_W:0]     rpt_err_sum,
    output logic [WIDTH:0]           rpt_max_err
);
    typedef enum logic [1:0] {ACCUM, DRAIN, REPORT} state_t;
    localparam logic [CNT_W:0] WIN = (CNT_W + 1)'(WINDOW);
    state_t               state, state_nx;
    logic                 ready_q, accept, close, rpt_done;
    logic                 s1_valid, s1_nz;
    logic [WIDTH:0]       exact, approx, err, s1_err;
    logic [CNT_W-1:0]     acc_cnt, samples, err_count;
    logic [WIDTH+CNT_W:0] err_sum;
    logic [WIDTH:0]       max_err;

    assign in_ready      = ready_q;
    assign rpt_valid     = state == REPORT;
    assign accept        = in_valid && in_ready;
    assign rpt_done      = rpt_valid && rpt_ready;
    assign rpt_samples   = samples;
    assign rpt_err_count = err_count;
    assign rpt_err_sum   = err_sum;
    assign rpt_max_err   = max_err;

    // exact sum and unsigned distance to the adder's result
    always_comb begin
        exact  = {1'b0, a} + {1'b0, b} + (WIDTH + 1)'(cin);
        approx = {approx_cout, approx_sum};
        err    = exact >= approx ? exact - approx : approx - exact;
    end

    // window closes on the last sample of the window or on a non-empty flush
    always_comb begin
        close    = (accept && ({1'b0, acc_cnt} + (CNT_W + 1)'(1)) == WIN)
                || (flush && (acc_cnt != '0 || accept));
        state_nx = state == ACCUM ? (close ? DRAIN : ACCUM)
                 : state == DRAIN ? REPORT
                 : (rpt_done ? ACCUM : REPORT);
    end

    // state register; in_ready is registered so it only rises after the first edge out of reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ACCUM;
            ready_q <= 1'b0;
        end else begin
            state   <= state_nx;
            ready_q <= state_nx == ACCUM;
        end
    end

    // stage 1: capture error of each accepted sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_err   <= '0;
            s1_nz    <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_err <= err;
                s1_nz  <= err != '0;
            end
        end
    end

    // accepted-sample counter for window closing
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            acc_cnt <= '0;
        else if (rpt_done)
            acc_cnt <= '0;
        else if (accept)
            acc_cnt <= acc_cnt + CNT_W'(1);
    end

    // stage 2: accumulate statistics; cleared when the report is consumed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            samples   <= '0;
            err_count <= '0;
            err_sum   <= '0;
            max_err   <= '0;
        end else if (rpt_done) begin
            samples   <= '0;
            err_count <= '0;
            err_sum   <= '0;
            max_err   <= '0;
        end else if (s1_valid) begin
            samples   <= samples + CNT_W'(1);
            err_count <= err_count + CNT_W'(s1_nz);
            err_sum   <= err_sum + {{CNT_W{1'b0}}, s1_err};
            max_err   <= s1_err > max_err ? s1_err : max_err;
        end
    end
endmodule
